// File: rtl/modn_cnt_pkg.sv
// Shared types, constants and helpers for the modulo-N synchronous counter.
// Latency: n/a (package). Backpressure: n/a.
// Contents: direction constants, operation enum, width/Gray helpers, parameter-legality macro.

`ifndef MODN_CNT_PKG_SV
`define MODN_CNT_PKG_SV

// Elaboration-time legality checks for a counter instance. Expands to
// generate blocks, so it must be used at module item level.
`define MODN_CNT_CHECK_PARAMS(MOD, RV) \
    if ((MOD) < 2) begin : g_bad_modulus \
        $error("modn counter: MODULUS must be >= 2"); \
    end \
    if (((RV) < 0) || ((RV) >= (MOD))) begin : g_bad_reset_val \
        $error("modn counter: RESET_VAL must be in 0..MODULUS-1"); \
    end

package modn_cnt_pkg;

    // Direction encoding on up_dn.
    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Operation selected on a given edge after clr > load > en priority.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_CLR  = 2'd1,
        OP_LOAD = 2'd2,
        OP_STEP = 2'd3
    } cnt_op_e;

    // Width of count/load bus; never below one bit.
    function automatic int cnt_width(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

    // Binary to reflected Gray code. Callers truncate to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

`endif

// File: rtl/modn_sync_counter_if.sv
// Control/status bundle of one modulo-N counter.
// Latency: n/a (wiring only). Backpressure: none; the counter accepts an operation every cycle.
// master drives en/up_dn/clr/load/load_val; slave (the counter) drives count/tc/wrap/load_err
// and, when MODN_CNT_GRAY_EN is defined, count_gray.

interface modn_sync_counter_if #(
    parameter int MODULUS = 5
) ();

    localparam int WIDTH = modn_cnt_pkg::cnt_width(MODULUS);

    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             load_err;
`ifdef MODN_CNT_GRAY_EN
    logic [WIDTH-1:0] count_gray;
`endif

    modport master (
        output en,
        output up_dn,
        output clr,
        output load,
        output load_val,
        input  count,
        input  tc,
        input  wrap,
`ifdef MODN_CNT_GRAY_EN
        input  count_gray,
`endif
        input  load_err
    );

    modport slave (
        input  en,
        input  up_dn,
        input  clr,
        input  load,
        input  load_val,
        output count,
        output tc,
        output wrap,
`ifdef MODN_CNT_GRAY_EN
        output count_gray,
`endif
        output load_err
    );

endinterface

// File: rtl/modn_cnt_next.sv
// Combinational step/load evaluation for the modulo-N counter (no priority, no state).
// Latency: zero (pure combinational). Backpressure: none.
// Ports: count/up_dn/load_val in; step_count, step_wrap, load_bad out.

module modn_cnt_next
    import modn_cnt_pkg::*;
#(
    parameter int MODULUS = 5,
    parameter int WIDTH   = cnt_width(MODULUS)
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] step_count,
    output logic             step_wrap,
    output logic             load_bad
);

    // One extra bit so that MODULUS itself is representable; this matters
    // for power-of-two moduli where MODULUS does not fit in WIDTH bits.
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] lv_ext;
    logic [WIDTH:0] step_ext;
    logic           at_top;
    logic           at_bot;

    assign cnt_ext = {1'b0, count};
    assign lv_ext  = {1'b0, load_val};
    assign at_top  = (cnt_ext == MAX_EXT);
    assign at_bot  = (cnt_ext == '0);

    always_comb begin
        step_ext  = cnt_ext;
        step_wrap = 1'b0;
        if (up_dn == CNT_UP) begin
            step_ext  = at_top ? '0 : cnt_ext + 1'b1;
            step_wrap = at_top;
        end else begin
            step_ext  = at_bot ? MAX_EXT : cnt_ext - 1'b1;
            step_wrap = at_bot;
        end
    end

    // step_ext never exceeds MAX_EXT, so the top bit is always zero here.
    assign step_count = step_ext[WIDTH-1:0];
    assign load_bad   = (lv_ext >= MOD_EXT);

endmodule

// File: rtl/modn_sync_counter.sv
// Parametrised modulo-N up/down counter with enable, sync clear/load, terminal-count carry.
// Latency: count/wrap/load_err update one clk edge after the operation is presented; tc is combinational.
// Backpressure: none; one operation (clr > load > en) is taken every cycle.
// Ports: clk, rst_n (async active-low), bus (modn_sync_counter_if.slave).
// Optional: MODN_CNT_GRAY_EN adds bus.count_gray, registered Gray code of count.

module modn_sync_counter
    import modn_cnt_pkg::*;
#(
    parameter int MODULUS   = 5,
    parameter int RESET_VAL = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    modn_sync_counter_if.slave bus
);

    localparam int WIDTH = cnt_width(MODULUS);

    `MODN_CNT_CHECK_PARAMS(MODULUS, RESET_VAL)

    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] TOP_CNT = WIDTH'(MODULUS - 1);

    cnt_op_e          op;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             lerr_q;
    logic             lerr_d;
    logic [WIDTH-1:0] step_count;
    logic             step_wrap;
    logic             load_bad;
    logic [WIDTH-1:0] terminal;

    modn_cnt_next #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_next (
        .count      (cnt_q),
        .up_dn      (bus.up_dn),
        .load_val   (bus.load_val),
        .step_count (step_count),
        .step_wrap  (step_wrap),
        .load_bad   (load_bad)
    );

    // Priority resolution: clr beats load, load beats en.
    always_comb begin
        op = OP_HOLD;
        if (bus.clr) begin
            op = OP_CLR;
        end else if (bus.load) begin
            op = OP_LOAD;
        end else if (bus.en) begin
            op = OP_STEP;
        end
    end

    // Pulses default low so that any cycle which does not wrap or reject a
    // load clears them; that is what makes them single-cycle.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        lerr_d = 1'b0;
        unique case (op)
            OP_CLR: begin
                cnt_d = RST_CNT;
            end
            OP_LOAD: begin
                if (load_bad) begin
                    lerr_d = 1'b1;
                end else begin
                    cnt_d = bus.load_val;
                end
            end
            OP_STEP: begin
                cnt_d  = step_count;
                wrap_d = step_wrap;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= RST_CNT;
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            lerr_q <= lerr_d;
        end
    end

    // tc deliberately ignores clr/load: a downstream stage uses it as its
    // enable and only cares whether this stage is about to roll over.
    assign terminal     = (bus.up_dn == CNT_DN) ? '0 : TOP_CNT;
    assign bus.tc       = bus.en & (cnt_q == terminal);
    assign bus.count    = cnt_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = lerr_q;

`ifdef MODN_CNT_GRAY_EN
    // Encoded from cnt_d so the Gray value lands on the same edge as count.
    // Non-power-of-two moduli wrap with a multi-bit Gray change.
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(32'(RESET_VAL)));

    logic [WIDTH-1:0] gray_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q <= RST_GRAY;
        end else begin
            gray_q <= WIDTH'(bin2gray(32'(cnt_d)));
        end
    end

    assign bus.count_gray = gray_q;
`endif

endmodule

// File: tb/tb_modn_sync_counter.sv
// Bench for modn_sync_counter: mod-5, mod-8 (reset value 3) and a two-stage mod-10 cascade
// checked every cycle against an arithmetic model, plus directed literal expectations.

module tb_modn_sync_counter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   chk_on = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    modn_sync_counter_if #(.MODULUS(5))  u5_if ();
    modn_sync_counter_if #(.MODULUS(8))  u8_if ();
    modn_sync_counter_if #(.MODULUS(10)) c0_if ();
    modn_sync_counter_if #(.MODULUS(10)) c1_if ();

    modn_sync_counter #(.MODULUS(5),  .RESET_VAL(0)) dut5  (.clk(clk), .rst_n(rst_n), .bus(u5_if));
    modn_sync_counter #(.MODULUS(8),  .RESET_VAL(3)) dut8  (.clk(clk), .rst_n(rst_n), .bus(u8_if));
    modn_sync_counter #(.MODULUS(10), .RESET_VAL(0)) dutc0 (.clk(clk), .rst_n(rst_n), .bus(c0_if));
    modn_sync_counter #(.MODULUS(10), .RESET_VAL(0)) dutc1 (.clk(clk), .rst_n(rst_n), .bus(c1_if));

    // mod-8 instance shares the mod-5 controls; cascade stage 1 enabled by stage 0 tc.
    assign u8_if.en       = u5_if.en;
    assign u8_if.up_dn    = u5_if.up_dn;
    assign u8_if.clr      = u5_if.clr;
    assign u8_if.load     = u5_if.load;
    assign u8_if.load_val = u5_if.load_val;
    assign c1_if.en       = c0_if.tc;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        int c;
        bit w;
        bit e;
    } mres_t;

    mres_t ms[4];

    function automatic mres_t mnext(input int m, input int rv, input int c,
                                    input bit en, input bit up, input bit clr,
                                    input bit ld, input int lv);
        mres_t r;
        r.c = c;
        r.w = 1'b0;
        r.e = 1'b0;
        if (clr) begin
            r.c = rv;
        end else if (ld) begin
            if (lv < m) r.c = lv;
            else        r.e = 1'b1;
        end else if (en) begin
            if (up) begin
                r.c = (c + 1) % m;
                r.w = (c == m - 1);
            end else begin
                r.c = (c + m - 1) % m;
                r.w = (c == 0);
            end
        end
        return r;
    endfunction

    // Model's view of stage 1 enable: stage 0 about to roll over.
    bit m_en1;
    assign m_en1 = c0_if.en && (ms[2].c == (c0_if.up_dn ? 9 : 0));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms[0] <= '{0, 1'b0, 1'b0};
            ms[1] <= '{3, 1'b0, 1'b0};
            ms[2] <= '{0, 1'b0, 1'b0};
            ms[3] <= '{0, 1'b0, 1'b0};
        end else begin
            ms[0] <= mnext(5, 0, ms[0].c, u5_if.en, u5_if.up_dn, u5_if.clr, u5_if.load, int'(u5_if.load_val));
            ms[1] <= mnext(8, 3, ms[1].c, u5_if.en, u5_if.up_dn, u5_if.clr, u5_if.load, int'(u5_if.load_val));
            ms[2] <= mnext(10, 0, ms[2].c, c0_if.en, c0_if.up_dn, c0_if.clr, c0_if.load, int'(c0_if.load_val));
            ms[3] <= mnext(10, 0, ms[3].c, m_en1, c1_if.up_dn, c1_if.clr, c1_if.load, int'(c1_if.load_val));
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string nm, input int i, input int m, input int cnt,
                            input bit tc, input bit w, input bit e, input bit en, input bit up);
        int term;
        term = up ? m - 1 : 0;
        check({nm, ".count"},    cnt,     ms[i].c);
        check({nm, ".tc"},       int'(tc), int'(en && (ms[i].c == term)));
        check({nm, ".wrap"},     int'(w), int'(ms[i].w));
        check({nm, ".load_err"}, int'(e), int'(ms[i].e));
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp_inst("m5", 0, 5, int'(u5_if.count), u5_if.tc, u5_if.wrap, u5_if.load_err, u5_if.en, u5_if.up_dn);
            cmp_inst("m8", 1, 8, int'(u8_if.count), u8_if.tc, u8_if.wrap, u8_if.load_err, u5_if.en, u5_if.up_dn);
            cmp_inst("c0", 2, 10, int'(c0_if.count), c0_if.tc, c0_if.wrap, c0_if.load_err, c0_if.en, c0_if.up_dn);
            cmp_inst("c1", 3, 10, int'(c1_if.count), c1_if.tc, c1_if.wrap, c1_if.load_err, m_en1, c1_if.up_dn);
`ifdef MODN_CNT_GRAY_EN
            check("m5.gray", int'(u5_if.count_gray), ms[0].c ^ (ms[0].c >> 1));
            check("m8.gray", int'(u8_if.count_gray), ms[1].c ^ (ms[1].c >> 1));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int t1[12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
    int t2[7]  = '{0, 4, 3, 2, 1, 0, 4};
    int gseq[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    initial begin
        u5_if.en = 1'b0; u5_if.up_dn = 1'b1; u5_if.clr = 1'b0; u5_if.load = 1'b0; u5_if.load_val = '0;
        c0_if.en = 1'b0; c0_if.up_dn = 1'b1; c0_if.clr = 1'b0; c0_if.load = 1'b0; c0_if.load_val = '0;
        c1_if.up_dn = 1'b1; c1_if.clr = 1'b0; c1_if.load = 1'b0; c1_if.load_val = '0;

        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        #1;
        check("rst_cnt5", int'(u5_if.count), 0);
        check("rst_cnt8", int'(u8_if.count), 3);
        check("rst_wrap5", int'(u5_if.wrap), 0);
        check("rst_lerr5", int'(u5_if.load_err), 0);
        #10 rst_n = 1'b1;

        // 1: count up, 12 cycles
        u5_if.en = 1'b1; u5_if.up_dn = 1'b1;
        #1;
        for (int k = 0; k < 12; k++) begin
            check("t1_count", int'(u5_if.count), t1[k]);
            check("t1_tc", int'(u5_if.tc), int'(t1[k] == 4));
            check("t1_wrap", int'(u5_if.wrap), int'(k > 0 && t1[k-1] == 4));
            cyc();
        end

        // 2: count down from 0
        u5_if.en = 1'b0; u5_if.clr = 1'b1;
        cyc();
        u5_if.clr = 1'b0;
        check("t2_clr5", int'(u5_if.count), 0);
        check("t2_clr8", int'(u5_if.count == 0 ? u8_if.count : 3'd0), 3);
        u5_if.up_dn = 1'b0; u5_if.en = 1'b1;
        #1;
        for (int k = 0; k < 7; k++) begin
            check("t2_count", int'(u5_if.count), t2[k]);
            check("t2_tc", int'(u5_if.tc), int'(t2[k] == 0));
            check("t2_wrap", int'(u5_if.wrap), int'(k > 0 && t2[k-1] == 0));
            cyc();
        end
        u5_if.en = 1'b0;

        // 3: good load then out-of-range load
        u5_if.load_val = 3'd3; u5_if.load = 1'b1;
        cyc();
        check("t3_load3", int'(u5_if.count), 3);
        check("t3_lerr_ok", int'(u5_if.load_err), 0);
        u5_if.load_val = 3'd6;
        cyc();
        check("t3_hold3", int'(u5_if.count), 3);
        check("t3_lerr", int'(u5_if.load_err), 1);
        check("t3_m8_load6", int'(u8_if.count), 6);
        check("t3_m8_lerr", int'(u8_if.load_err), 0);
        u5_if.load = 1'b0;
        cyc();
        check("t3_lerr_pulse", int'(u5_if.load_err), 0);
        check("t3_still3", int'(u5_if.count), 3);

        // 4: clr + load + en together at count 2
        u5_if.load_val = 3'd2; u5_if.load = 1'b1;
        cyc();
        check("t4_pre", int'(u5_if.count), 2);
        u5_if.clr = 1'b1; u5_if.en = 1'b1; u5_if.up_dn = 1'b0; u5_if.load_val = 3'd7;
        cyc();
        check("t4_count", int'(u5_if.count), 0);
        check("t4_wrap", int'(u5_if.wrap), 0);
        check("t4_lerr", int'(u5_if.load_err), 0);
        check("t4_m8_count", int'(u8_if.count), 3);
        check("t4_tc_ignores_clr", int'(u5_if.tc), 1);
        u5_if.clr = 1'b0; u5_if.load = 1'b0; u5_if.en = 1'b0; u5_if.up_dn = 1'b1;

        // 5: two-stage mod-10 cascade, 100 cycles
        c0_if.en = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            cyc();
            if (n == 10) check("t5_c1_at10", int'(c1_if.count), 1);
            if (n == 55) begin
                check("t5_c0_at55", int'(c0_if.count), 5);
                check("t5_c1_at55", int'(c1_if.count), 5);
            end
        end
        check("t5_c0_at100", int'(c0_if.count), 0);
        check("t5_c1_at100", int'(c1_if.count), 0);
        check("t5_c1_wrap", int'(c1_if.wrap), 1);
        c0_if.en = 1'b0;

        // 6: power-of-two count (Gray when enabled), then async reset mid-count
        u5_if.load_val = 3'd0; u5_if.load = 1'b1;
        cyc();
        u5_if.load = 1'b0; u5_if.en = 1'b1; u5_if.up_dn = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("t6_m8_count", int'(u8_if.count), k);
`ifdef MODN_CNT_GRAY_EN
            check("t6_m8_gray", int'(u8_if.count_gray), gseq[k]);
`endif
            cyc();
        end
        check("t6_m8_wrapcnt", int'(u8_if.count), 0);
        check("t6_m8_wrap", int'(u8_if.wrap), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_cnt5", int'(u5_if.count), 0);
        check("t6_rst_cnt8", int'(u8_if.count), 3);
        check("t6_rst_wrap8", int'(u8_if.wrap), 0);
        check("t6_rst_c1", int'(c1_if.count), 0);
`ifdef MODN_CNT_GRAY_EN
        check("t6_rst_gray8", int'(u8_if.count_gray), 2);
`endif
        cyc();
        check("t6_rst_held", int'(u8_if.count), 3);
        rst_n = 1'b1;
        cyc();
        check("t6_post_rst8", int'(u8_if.count), 4);
        check("t6_post_rst5", int'(u5_if.count), 1);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
